// File: rtl/reg_alu_sequencer_if.sv
// Instruction handshake channel between the controller and the ALU sequencer.
// The controller is the master; the sequencer is the slave.
interface reg_alu_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        opcode;
    logic [1:0]        src_a;
    logic [1:0]        src_b;
    logic [1:0]        dst;
    logic [DATA_W-1:0] imm;

    modport master (
        output instr_valid,
        output opcode,
        output src_a,
        output src_b,
        output dst,
        output imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  opcode,
        input  src_a,
        input  src_b,
        input  dst,
        input  imm,
        output instr_ready
    );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Three-state instruction sequencer and ALU in front of a 4 x DATA_W register bank.
// It reads operands through the bank's combinational ports and writes back via an active-low enable.
module reg_alu_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    reg_alu_sequencer_if.slave  instr,
    output logic [1:0]          add_rd0,
    output logic [1:0]          add_rd1,
    input  logic [DATA_W-1:0]   rd0,
    input  logic [DATA_W-1:0]   rd1,
    output logic [1:0]          add_wr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_en,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic                carry,
    output logic                zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_LDI = 3'd6,
        OP_SHL = 3'd7
    } opcode_t;

    state_t            state;
    state_t            next_state;
    opcode_t           op_q;
    logic [1:0]        dst_q;
    logic [DATA_W-1:0] imm_q;
    logic              accept;

    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign accept = instr.instr_valid && instr.instr_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // wr_en and done decode straight from state, so an asynchronous reset
    // landing in WRITE releases the bank write enable immediately.
    // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        next_state        = state;
        instr.instr_ready = 1'b0;
        wr_en             = 1'b1;
        done              = 1'b0;
        unique case (state)
            IDLE: begin
                instr.instr_ready = 1'b1;
                if (instr.instr_valid) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = WRITE;
            end
            WRITE: begin
                wr_en      = 1'b0;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One DATA_W+1-bit sum carries the carry/borrow/shift-out bit for every arithmetic op.
    always_comb begin
        alu_sum    = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                alu_sum    = {1'b0, rd0} + {1'b0, rd1};
                alu_result = alu_sum[DATA_W-1:0];
                alu_carry  = alu_sum[DATA_W];
            end
            OP_SUB: begin
                alu_sum    = {1'b0, rd0} - {1'b0, rd1};
                alu_result = alu_sum[DATA_W-1:0];
                alu_carry  = alu_sum[DATA_W];
            end
            OP_AND: alu_result = rd0 & rd1;
            OP_OR:  alu_result = rd0 | rd1;
            OP_XOR: alu_result = rd0 ^ rd1;
            OP_MOV: alu_result = rd0;
            OP_LDI: alu_result = imm_q;
            OP_SHL: begin
                alu_sum    = {rd0, 1'b0};
                alu_result = alu_sum[DATA_W-1:0];
                alu_carry  = alu_sum[DATA_W];
            end
            default: alu_result = '0;
        endcase
    end

    // NOTE: the capture and result registers drive outputs directly, so all of them are reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q    <= OP_ADD;
            dst_q   <= '0;
            imm_q   <= '0;
            add_rd0 <= '0;
            add_rd1 <= '0;
            add_wr  <= '0;
            wr_data <= '0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= opcode_t'(instr.opcode);
                add_rd0 <= instr.src_a;
                add_rd1 <= instr.src_b;
                dst_q   <= instr.dst;
                imm_q   <= instr.imm;
            end
            if (state == EXEC) begin
                result  <= alu_result;
                carry   <= alu_carry;
                zero    <= (alu_result == '0);
                wr_data <= alu_result;
                add_wr  <= dst_q;
            end
        end
    end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Directed bench for reg_alu_sequencer with a behavioural 4 x 8-bit register bank.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_reg_alu_sequencer;

    localparam int DATA_W = 8;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, MOV = 3'd5, LDI = 3'd6, SHL = 3'd7;
    localparam logic [26:0] RESET_OUTS = {1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};

    logic              clock;
    logic              reset;
    logic [1:0]        add_rd0, add_rd1, add_wr;
    logic [DATA_W-1:0] rd0, rd1, wr_data, result;
    logic              wr_en, done, carry, zero;

    logic [DATA_W-1:0] bank [4] = '{default: 8'h00};
    int n_checks = 0;
    int n_fails  = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    int cyc      = 0;

    reg_alu_sequencer_if #(.DATA_W(DATA_W)) bus ();

    reg_alu_sequencer #(.DATA_W(DATA_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .instr   (bus.slave),
        .add_rd0 (add_rd0),
        .add_rd1 (add_rd1),
        .rd0     (rd0),
        .rd1     (rd1),
        .add_wr  (add_wr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zero    (zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign rd0 = bank[add_rd0];
    assign rd1 = bank[add_rd1];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!wr_en) begin
            bank[add_wr] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [26:0] outs();
        return {bus.instr_ready, wr_en, done, add_rd0, add_rd1, add_wr, wr_data, result, carry, zero};
    endfunction

    // Issues one instruction from a falling edge and follows it through EXEC, WRITE and commit.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] d, input logic [7:0] im,
                             input logic [7:0] exp_r, input logic exp_c, input logic exp_z);
        int waited;
        bus.opcode = op; bus.src_a = a; bus.src_b = b; bus.dst = d; bus.imm = im;
        bus.instr_valid = 1'b1;
        waited = 0;
        while (!bus.instr_ready && waited < 10) begin @(negedge clock); waited++; end
        n_checks++;
        if (bus.instr_ready !== 1'b1) begin
            n_fails++; $display("FAIL handshake_timeout op=%0d: instr_ready=%b required=1", op, bus.instr_ready);
        end
        @(negedge clock);
        bus.instr_valid = 1'b0;
        n_checks++;
        if ({bus.instr_ready, wr_en, done, add_rd0, add_rd1} !== {1'b0, 1'b1, 1'b0, a, b}) begin
            n_fails++; $display("FAIL exec op=%0d: ready/wr_en/done/rd0/rd1=%b/%b/%b/%0d/%0d required 0/1/0/%0d/%0d",
                                op, bus.instr_ready, wr_en, done, add_rd0, add_rd1, a, b);
        end
        @(negedge clock);
        n_checks++;
        if ({wr_en, done, add_wr, wr_data} !== {1'b0, 1'b1, d, exp_r}) begin
            n_fails++; $display("FAIL write op=%0d: wr_en/done/add_wr/wr_data=%b/%b/%0d/%h required 0/1/%0d/%h",
                                op, wr_en, done, add_wr, wr_data, d, exp_r);
        end
        n_checks++;
        if ({result, carry, zero} !== {exp_r, exp_c, exp_z}) begin
            n_fails++; $display("FAIL flags op=%0d: result/carry/zero=%h/%b/%b required %h/%b/%b",
                                op, result, carry, zero, exp_r, exp_c, exp_z);
        end
        @(negedge clock);
        n_checks++;
        if ({bus.instr_ready, done, bank[d]} !== {1'b1, 1'b0, exp_r}) begin
            n_fails++; $display("FAIL commit op=%0d: ready/done/bank[%0d]=%b/%b/%h required 1/0/%h",
                                op, d, bus.instr_ready, done, bank[d], exp_r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (outs() !== RESET_OUTS) begin
            n_fails++; $display("FAIL reset_values: outs=%h required %h", outs(), RESET_OUTS);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (outs() !== RESET_OUTS) begin
            n_fails++; $display("FAIL idle_after_reset: outs=%h required %h", outs(), RESET_OUTS);
        end
    endtask

    task automatic test_basic();
        int d0, w0;
        d0 = done_cnt; w0 = wr_cnt;
        run_instr(LDI, 2'd0, 2'd0, 2'd1, 8'h2A, 8'h2A, 1'b0, 1'b0);
        run_instr(LDI, 2'd0, 2'd0, 2'd2, 8'h05, 8'h05, 1'b0, 1'b0);
        run_instr(ADD, 2'd1, 2'd2, 2'd3, 8'h00, 8'h2F, 1'b0, 1'b0);
        n_checks++;
        if ((done_cnt - d0) !== 3 || (wr_cnt - w0) !== 3) begin
            n_fails++; $display("FAIL basic_pulses: done=%0d writes=%0d required 3/3", done_cnt - d0, wr_cnt - w0);
        end
    endtask

    task automatic test_overflow_shift();
        run_instr(LDI, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_instr(LDI, 2'd0, 2'd0, 2'd1, 8'h01, 8'h01, 1'b0, 1'b0);
        run_instr(ADD, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1);
        run_instr(SHL, 2'd0, 2'd0, 2'd3, 8'h00, 8'hFE, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        run_instr(LDI, 2'd0, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0);
        run_instr(LDI, 2'd0, 2'd0, 2'd1, 8'h07, 8'h07, 1'b0, 1'b0);
        run_instr(SUB, 2'd0, 2'd1, 2'd2, 8'h00, 8'hFC, 1'b1, 1'b0);
        run_instr(SUB, 2'd1, 2'd0, 2'd2, 8'h00, 8'h04, 1'b0, 1'b0);
        run_instr(SUB, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_logic();
        run_instr(LDI,  2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0);
        run_instr(LDI,  2'd0, 2'd0, 2'd1, 8'h3C, 8'h3C, 1'b0, 1'b0);
        run_instr(AND_, 2'd0, 2'd1, 2'd2, 8'h00, 8'h30, 1'b0, 1'b0);
        run_instr(OR_,  2'd0, 2'd1, 2'd2, 8'h00, 8'hFC, 1'b0, 1'b0);
        run_instr(XOR_, 2'd0, 2'd1, 2'd2, 8'h00, 8'hCC, 1'b0, 1'b0);
        run_instr(MOV,  2'd1, 2'd0, 2'd3, 8'h00, 8'h3C, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops  [4] = '{LDI, LDI, ADD, XOR_};
        logic [1:0] sa   [4] = '{2'd0, 2'd0, 2'd0, 2'd2};
        logic [1:0] sb   [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
        logic [1:0] ds   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] ims  [4] = '{8'h11, 8'h22, 8'h00, 8'h00};
        logic [7:0] exps [4] = '{8'h11, 8'h22, 8'h33, 8'h22};
        int acc [4];
        int waited;
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.opcode = ops[k]; bus.src_a = sa[k]; bus.src_b = sb[k]; bus.dst = ds[k]; bus.imm = ims[k];
            waited = 0;
            while (!bus.instr_ready && waited < 10) begin @(negedge clock); waited++; end
            acc[k] = cyc;
            @(negedge clock);
            n_checks++;
            if (bus.instr_ready !== 1'b0) begin
                n_fails++; $display("FAIL b2b_exec_ready k=%0d: ready=%b required 0", k, bus.instr_ready);
            end
            // A different instruction while busy must be ignored.
            bus.opcode = LDI; bus.src_a = 2'd3; bus.src_b = 2'd3; bus.dst = 2'd0; bus.imm = 8'h99;
            @(negedge clock);
            n_checks++;
            if ({bus.instr_ready, wr_en, add_wr, result} !== {1'b0, 1'b0, ds[k], exps[k]}) begin
                n_fails++; $display("FAIL b2b_write k=%0d: ready/wr_en/add_wr/result=%b/%b/%0d/%h required 0/0/%0d/%h",
                                    k, bus.instr_ready, wr_en, add_wr, result, ds[k], exps[k]);
            end
        end
        bus.instr_valid = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ((acc[k+1] - acc[k]) !== 3) begin
                n_fails++; $display("FAIL b2b_spacing k=%0d: gap=%0d required 3", k, acc[k+1] - acc[k]);
            end
        end
        n_checks++;
        if ({bank[0], bank[1], bank[2], bank[3]} !== {8'h11, 8'h22, 8'h33, 8'h22}) begin
            n_fails++; $display("FAIL b2b_bank: r0..r3=%h %h %h %h required 11 22 33 22",
                                bank[0], bank[1], bank[2], bank[3]);
        end
    endtask

    task automatic test_reset_mid(input bit in_write);
        int d0, w0, waited;
        d0 = done_cnt; w0 = wr_cnt;
        bus.opcode = LDI; bus.src_a = 2'd0; bus.src_b = 2'd0; bus.dst = 2'd1;
        bus.imm = in_write ? 8'h66 : 8'h77;
        bus.instr_valid = 1'b1;
        waited = 0;
        while (!bus.instr_ready && waited < 10) begin @(negedge clock); waited++; end
        @(negedge clock);
        bus.instr_valid = 1'b0;
        if (in_write) @(negedge clock);
        n_checks++;
        if (wr_en !== !in_write) begin
            n_fails++; $display("FAIL reset_mid_setup write=%0b: wr_en=%b required %b", in_write, wr_en, !in_write);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== RESET_OUTS) begin
            n_fails++; $display("FAIL reset_mid_outs write=%0b: outs=%h required %h", in_write, outs(), RESET_OUTS);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({bus.instr_ready, bank[1]} !== {1'b1, 8'h22} || (done_cnt - d0) !== 0 || (wr_cnt - w0) !== 0) begin
            n_fails++; $display("FAIL reset_mid_abort write=%0b: ready=%b bank[1]=%h done=%0d writes=%0d required 1/22/0/0",
                                in_write, bus.instr_ready, bank[1], done_cnt - d0, wr_cnt - w0);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.instr_valid = 1'b0; bus.opcode = '0; bus.src_a = '0; bus.src_b = '0; bus.dst = '0; bus.imm = '0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_overflow_shift();
        test_sub();
        test_logic();
        test_back_to_back();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        run_instr(MOV, 2'd1, 2'd1, 2'd3, 8'h00, 8'h22, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
